hovalaag_input_queue: RTL and testbench
=======================================

Name: hovalaag_input_queue

Overview:
- Two independent 12-bit FIFOs that buffer host-supplied input streams and present them to the CPU core's IN1/IN2 ports.
- Sits directly upstream of the CPU core.
- Host side: single valid/ready write port with a channel select.
- CPU side: head-of-queue words shown combinationally; each queue pops on the core's IN1_adv/IN2_adv strobe.
- The core cannot stall, so an empty read returns zero and sets a sticky underflow flag for the test harness.

Parameters:
- DEPTH, 16: entries per queue; power of two, minimum 2.
- AW, $clog2(DEPTH): address width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high.
- wr_data  in  12  word to enqueue
- wr_sel  in  1  target queue: 0 = queue 1, 1 = queue 2
- wr_valid  in  1  host presents wr_data
- wr_ready  out  1  selected queue can accept this cycle
- IN1  out  12  head of queue 1; 12'h000 when empty
- IN1_adv  in  1  pop queue 1 (from core)
- IN2  out  12  head of queue 2; 12'h000 when empty
- IN2_adv  in  1  pop queue 2 (from core)
- empty1  out  1  queue 1 holds no entries
- empty2  out  1  queue 2 holds no entries
- underflow  out  2  sticky; bit0 = pop of empty queue 1, bit1 = pop of empty queue 2

Behaviour:
- Per queue state:
  - storage array of DEPTH x 12 bits
  - read pointer and write pointer, each AW+1 bits, wrapping naturally at 2*DEPTH
  - empty = pointers equal
  - full = low AW bits equal and MSBs differ
- Flags:
  - wr_ready = !full of the queue named by wr_sel; combinational.
  - wr_ready does not depend on wr_valid or on the pop strobes.
- Push: on posedge with wr_valid && wr_ready, write wr_data at the selected queue's write pointer and increment it.
- Pop: on posedge with INx_adv && !emptyx, increment read pointer x.
- Head data:
  - INx = storage[rdptr x] when non-empty, else 12'h000.
  - Combinational from registered state, so the core samples the head on the same edge that pops it.
  - A newly pushed word becomes visible on INx the cycle after the push edge.
- Latency: one cycle write-to-visible; zero cycles pop-to-next-head (new head valid after the pop edge).
- Simultaneous push and pop, same queue:
  - Non-empty and non-full: both occur; occupancy is unchanged.
  - Full: wr_ready is low, so the push is refused; the pop occurs. The host may push next cycle.
  - Empty: the pop is ignored and sets underflow; the push is stored. No same-cycle pass-through; INx stays 12'h000 that cycle.
- Pop of an empty queue:
  - pointers unchanged
  - underflow[x] set and held until rst
- Queues are fully independent; IN1_adv and IN2_adv may both be asserted in the same cycle.
- Reset (rst high at posedge):
  - all pointers = 0; underflow = 2'b00
  - empty1 = empty2 = 1; IN1 = IN2 = 12'h000; wr_ready = 1
  - Storage contents are not cleared.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-stream discards all queued words.

Optional Feature:
- Macro: HOVALAAG_INQ_LEVEL_EN.
- Defined: adds outputs level1 and level2, each AW+1 bits, giving the current occupancy (wrptr - rdptr, range 0..DEPTH). Registered-state derived; reset to 0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then push 12'h123 and 12'hABC to queue 1 -> IN1 = 12'h123 one cycle after the first push; pulse IN1_adv -> IN1 = 12'hABC; pulse IN1_adv -> empty1 = 1, IN1 = 12'h000, underflow = 2'b00.
- Push DEPTH words 0..15 to queue 2 -> wr_ready low with wr_sel = 1, high with wr_sel = 0. A 17th push is refused. Pop all 16 -> IN2 reads 0..15 in order; then empty2 = 1.
- Queue 2 full, wr_valid = 1 with wr_sel = 1 and IN2_adv = 1 in the same cycle -> push refused, one pop occurs; next cycle a push is accepted and the queue is full again.
- Queue 1 empty, push 12'h7FF and IN1_adv in the same cycle -> underflow = 2'b01; next cycle IN1 = 12'h7FF, empty1 = 0.
- Interleave writes to both queues (q1: 1,2,3; q2: 10,20) and pop both in the same cycles -> each queue preserves its own order with no cross-talk. Run 40 push/pop pairs to exercise pointer wrap past 2*DEPTH.
- Load 5 words, assert rst for one cycle while also pushing and popping -> after reset both queues empty, IN1 = IN2 = 12'h000, underflow = 0. With HOVALAAG_INQ_LEVEL_EN defined, level1 = level2 = 0.

Source files
------------

// File: rtl/hovalaag_input_queue.sv
// hovalaag_input_queue
//   Two independent 12-bit FIFOs. The host fills them and the CPU core drains
//   them through its IN1/IN2 ports. The core cannot stall. A read of an empty
//   queue therefore returns zero and sets a sticky underflow bit, which the
//   test harness can inspect.
//
// Parameters
//   DEPTH  entries per queue (power of two, >= 2)
//   AW     address width, derived from DEPTH
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   wr_data/sel/valid    host write port (sel 0 = queue 1, 1 = queue 2)
//   wr_ready             the selected queue is not full (combinational)
//   IN1/IN2              head of each queue, 12'h000 when empty
//   IN1_adv/IN2_adv      pop strobes from the core
//   empty1/empty2        queue holds no entries
//   underflow[1:0]       sticky pop-while-empty flags, cleared only by rst
//   level1/level2        occupancy 0..DEPTH; present only when the macro
//                        HOVALAAG_INQ_LEVEL_EN is defined
module hovalaag_input_queue #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [11:0]   wr_data,
    input  logic          wr_sel,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [11:0]   IN1,
    input  logic          IN1_adv,
    output logic [11:0]   IN2,
    input  logic          IN2_adv,
    output logic          empty1,
    output logic          empty2,
    output logic [1:0]    underflow
`ifdef HOVALAAG_INQ_LEVEL_EN
    ,
    output logic [AW:0]   level1,
    output logic [AW:0]   level2
`endif
);

    logic [1:0]        adv;
    logic [1:0]        empty;
    logic [1:0]        full;
    logic [1:0][11:0]  head;

    assign adv = {IN2_adv, IN1_adv};

    // Readiness depends only on the fullness of the addressed queue. It does
    // not look at wr_valid or at the pops, so it carries no combinational
    // path from the core's strobes.
    assign wr_ready = !full[wr_sel];

`ifdef HOVALAAG_INQ_LEVEL_EN
    logic [1:0][AW:0]  level;
    assign level1 = level[0];
    assign level2 = level[1];
`endif

    for (genvar q = 0; q < 2; q++) begin : g_q
        logic [11:0] mem_q [DEPTH];
        logic [AW:0] rdptr_q, rdptr_d;
        logic [AW:0] wrptr_q, wrptr_d;
        logic        uf_q, uf_d;
        logic        push, pop;

        assign push = wr_valid && wr_ready && (int'(wr_sel) == q);
        assign pop  = adv[q] && !empty[q];

        // The pointers carry one extra wrap bit. This tells full apart from
        // empty when the two index fields are equal.
        assign empty[q] = (rdptr_q == wrptr_q);
        assign full[q]  = (rdptr_q[AW-1:0] == wrptr_q[AW-1:0]) &&
                          (rdptr_q[AW] != wrptr_q[AW]);

        // The head is read straight from registered state. The core samples
        // it on the same edge that pops it.
        assign head[q] = empty[q] ? 12'h000 : mem_q[rdptr_q[AW-1:0]];

`ifdef HOVALAAG_INQ_LEVEL_EN
        assign level[q] = wrptr_q - rdptr_q;
`endif

        always_comb begin
            wrptr_d = wrptr_q;
            rdptr_d = rdptr_q;
            uf_d    = uf_q;
            if (push) wrptr_d = wrptr_q + 1'b1;
            if (pop)  rdptr_d = rdptr_q + 1'b1;
            if (adv[q] && empty[q]) uf_d = 1'b1;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdptr_q <= '0;
                wrptr_q <= '0;
                uf_q    <= 1'b0;
            end else begin
                rdptr_q <= rdptr_d;
                wrptr_q <= wrptr_d;
                uf_q    <= uf_d;
            end
        end

        // Storage has no reset. Entries become visible only through the
        // pointers, and reset clears the pointers.
        always_ff @(posedge clk) begin
            if (push && !rst) mem_q[wrptr_q[AW-1:0]] <= wr_data;
        end

        assign underflow[q] = uf_q;
    end

    assign IN1    = head[0];
    assign IN2    = head[1];
    assign empty1 = empty[0];
    assign empty2 = empty[1];

endmodule

// File: tb/tb_hovalaag_input_queue.sv
module tb_hovalaag_input_queue;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] wr_data;
    logic        wr_sel, wr_valid, wr_ready;
    logic [11:0] IN1, IN2;
    logic        IN1_adv, IN2_adv, empty1, empty2;
    logic [1:0]  underflow;
`ifdef HOVALAAG_INQ_LEVEL_EN
    logic [AW:0] level1, level2;
`endif

    hovalaag_input_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_sel(wr_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .IN1(IN1), .IN1_adv(IN1_adv),
        .IN2(IN2), .IN2_adv(IN2_adv), .empty1(empty1), .empty2(empty2),
        .underflow(underflow)
`ifdef HOVALAAG_INQ_LEVEL_EN
        , .level1(level1), .level2(level2)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [11:0] exp1[$];
    logic [11:0] exp2[$];
    logic [1:0]  uf_m   = 2'b00;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on each falling edge, compare the DUT against the scoreboard
    // queues. After the compare, retire the entries that the next rising edge
    // pops.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp1.size() != 0) begin
                chk("IN1", 32'(IN1), 32'(exp1[0]));
                chk("empty1", 32'(empty1), 32'd0);
            end else begin
                chk("IN1_zero", 32'(IN1), 32'd0);
                chk("empty1", 32'(empty1), 32'd1);
            end
            if (exp2.size() != 0) begin
                chk("IN2", 32'(IN2), 32'(exp2[0]));
                chk("empty2", 32'(empty2), 32'd0);
            end else begin
                chk("IN2_zero", 32'(IN2), 32'd0);
                chk("empty2", 32'(empty2), 32'd1);
            end
            chk("underflow", 32'(underflow), 32'(uf_m));
            chk("wr_ready", 32'(wr_ready),
                32'(((wr_sel ? exp2.size() : exp1.size()) != DEPTH)));
`ifdef HOVALAAG_INQ_LEVEL_EN
            chk("level1", 32'(level1), 32'(exp1.size()));
            chk("level2", 32'(level2), 32'(exp2.size()));
`endif
            if (IN1_adv) begin
                if (exp1.size() != 0) void'(exp1.pop_front());
                else uf_m[0] = 1'b1;
            end
            if (IN2_adv) begin
                if (exp2.size() != 0) void'(exp2.pop_front());
                else uf_m[1] = 1'b1;
            end
        end
    end

    // Drive one cycle of stimulus. 'acc' is the hand-determined acceptance of
    // the push; an accepted word joins its expected queue after the edge.
    task automatic step(input bit v, input bit sel, input logic [11:0] d,
                        input bit a1, input bit a2, input bit acc);
        wr_valid = v; wr_sel = sel; wr_data = d; IN1_adv = a1; IN2_adv = a2;
        @(posedge clk);
        if (v && acc) begin
            if (sel) exp2.push_back(d);
            else     exp1.push_back(d);
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_data = '0;
        IN1_adv = 1'b0; IN2_adv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_empty1", 32'(empty1), 32'd1);
        chk("rst_empty2", 32'(empty2), 32'd1);
        chk("rst_IN1", 32'(IN1), 32'd0);
        chk("rst_IN2", 32'(IN2), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);

        // Basic push and pop on queue 1.
        step(1, 0, 12'h123, 0, 0, 1);
        chk("t1_IN1_first", 32'(IN1), 32'h123);
        step(1, 0, 12'hABC, 0, 0, 1);
        step(0, 0, 12'h000, 1, 0, 0);
        chk("t1_IN1_second", 32'(IN1), 32'hABC);
        step(0, 0, 12'h000, 1, 0, 0);
        chk("t1_empty1", 32'(empty1), 32'd1);
        chk("t1_IN1_zero", 32'(IN1), 32'd0);
        chk("t1_underflow", 32'(underflow), 32'd0);

        // Fill queue 2, check that the 17th push is refused, then check a
        // push and a pop in the same cycle while the queue is full.
        for (int i = 0; i < DEPTH; i++) step(1, 1, 12'(i), 0, 0, 1);
        wr_sel = 1'b1; #1;
        chk("t2_ready_sel1_full", 32'(wr_ready), 32'd0);
        wr_sel = 1'b0; #1;
        chk("t2_ready_sel0", 32'(wr_ready), 32'd1);
        step(1, 1, 12'hEEE, 0, 0, 0);
        step(1, 1, 12'h0AA, 0, 1, 0);
        step(1, 1, 12'h0BB, 0, 0, 1);
        wr_sel = 1'b1; #1;
        chk("t3_full_again", 32'(wr_ready), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 12'h000, 0, 1, 0);
        chk("t2_empty2", 32'(empty2), 32'd1);

        // Push and pop on queue 1 in the same cycle while it is empty.
        step(1, 0, 12'h7FF, 1, 0, 1);
        chk("t4_underflow", 32'(underflow), 32'b01);
        chk("t4_IN1", 32'(IN1), 32'h7FF);
        chk("t4_empty1", 32'(empty1), 32'd0);
        step(0, 0, 12'h000, 1, 0, 0);

        // Interleave writes to both queues, then pop both together.
        step(1, 0, 12'd1, 0, 0, 1);
        step(1, 1, 12'd10, 0, 0, 1);
        step(1, 0, 12'd2, 0, 0, 1);
        step(1, 1, 12'd20, 0, 0, 1);
        step(1, 0, 12'd3, 0, 0, 1);
        step(0, 0, 12'h000, 1, 1, 0);
        chk("t5_IN1", 32'(IN1), 32'd2);
        chk("t5_IN2", 32'(IN2), 32'd20);
        step(0, 0, 12'h000, 1, 1, 0);
        step(0, 0, 12'h000, 1, 0, 0);

        // Run 40 push/pop pairs so the pointers wrap past 2*DEPTH.
        step(1, 0, 12'd100, 0, 0, 1);
        for (int i = 1; i <= 40; i++) step(1, 0, 12'(100 + i), 1, 0, 1);
        chk("t5_wrap_head", 32'(IN1), 32'd140);
        step(0, 0, 12'h000, 1, 0, 0);

        // Assert reset mid-stream while also pushing and popping.
        step(1, 0, 12'h011, 0, 0, 1);
        step(1, 0, 12'h022, 0, 0, 1);
        step(1, 0, 12'h033, 0, 0, 1);
        step(1, 1, 12'h044, 0, 0, 1);
        step(1, 1, 12'h055, 0, 0, 1);
        rst = 1'b1;
        step(1, 0, 12'h066, 1, 1, 0);
        rst = 1'b0;
        exp1.delete(); exp2.delete(); uf_m = 2'b00;
        chk("t6_empty1", 32'(empty1), 32'd1);
        chk("t6_empty2", 32'(empty2), 32'd1);
        chk("t6_IN1", 32'(IN1), 32'd0);
        chk("t6_IN2", 32'(IN2), 32'd0);
        chk("t6_underflow", 32'(underflow), 32'd0);
`ifdef HOVALAAG_INQ_LEVEL_EN
        chk("t6_level1", 32'(level1), 32'd0);
        chk("t6_level2", 32'(level2), 32'd0);
`endif
        idle();
        idle();

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
